// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
//
// Bundles every non-clock signal of alu_op_sequencer into one interface.
//
// Signal groups:
//   Request channel  : req_valid, req_ready, req_op[3:0], req_a[N-1:0], req_b[N-1:0]
//   Response channel : rsp_valid, rsp_ready, rsp_result[N-1:0], rsp_carry, rsp_illegal
//   ALU connection   : alu_a, alu_b, alu_carry_in, alu_operation[3:0]  (sequencer -> ALU)
//                      alu_out, alu_carry_out                           (ALU -> sequencer)
//
// Modports:
//   slave  : the sequencer. It consumes requests, produces responses and
//            drives the ALU inputs.
//   master : the environment around it. This is the request producer, the
//            response consumer and the ALU itself.
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int N = 64
);
    // Request channel
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;

    // ALU connection
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         alu_carry_in;
    logic [3:0]   alu_operation;
    logic [N-1:0] alu_out;
    logic         alu_carry_out;

    // Response channel
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_illegal;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output alu_a, alu_b, alu_carry_in, alu_operation,
        input  alu_out, alu_carry_out,
        output rsp_valid, rsp_result, rsp_carry, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  alu_a, alu_b, alu_carry_in, alu_operation,
        output alu_out, alu_carry_out,
        input  rsp_valid, rsp_result, rsp_carry, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Multi-cycle execute-stage sequencer placed in front of an N-bit ripple-carry
// ALU. It accepts one RISC-V integer op at a time. It runs that op as a
// sequence of ALU passes, or as a run of internal one-bit right shifts. It then
// returns the result over a valid/ready response channel.
//
// The ALU Operation input is encoded {Ainvert, Binvert, sel[1:0]}:
//   sel 00 = AND, sel 01 = OR, sel 10 = ADD.
// The ALU has no XOR and no compare or shift-left function. Those ops are
// built from several passes:
//   XOR  : t = a & b, u = a | b, result = u & ~t
//   SLT  : one subtract pass, then a sign/overflow fix-up
//   SLTU : one subtract pass, result = ~carry_out
//   SLL  : shamt passes of acc + acc
// SRL and SRA never use the ALU. They shift an accumulator right by one bit
// per cycle.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset. It discards any in-flight op.
//   bus    : alu_op_sequencer_if.slave, carrying these signal groups:
//              request  : req_valid / req_ready / req_op / req_a / req_b
//              ALU      : alu_a / alu_b / alu_carry_in / alu_operation
//                         (driven), alu_out / alu_carry_out (sampled)
//              response : rsp_valid / rsp_ready / rsp_result / rsp_carry /
//                         rsp_illegal
//
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL,
//          9 SRA. Opcodes 10-15 are illegal: the response is 0 with
//          rsp_illegal set.
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int N       = 64,
    parameter int SHAMT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);

    // Request opcodes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    // ALU Operation codes, {Ainvert, Binvert, sel[1:0]}
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;  // a + ~b + 1 (needs carry-in 1)
    localparam logic [3:0] ALU_ANDN = 4'b0100;  // a & ~b

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;

    // Captured request and working registers
    logic [3:0]         op_q;
    logic [N-1:0]       acc_q;      // operand A, then the SLL/SRL/SRA accumulator
    logic [N-1:0]       b_q;
    logic [N-1:0]       t_q;        // XOR partial: a & b
    logic [N-1:0]       u_q;        // XOR partial: a | b
    logic [SHAMT_W-1:0] shamt_q;
    logic [SHAMT_W-1:0] pass_q;
    logic               sign_q;     // original a[N-1]; the SRA fill bit

    // Response registers
    logic [N-1:0]       res_q;
    logic               carry_q;
    logic               illegal_q;

    // Combinational ALU drive and per-pass decode
    logic [N-1:0]       alu_a_c;
    logic [N-1:0]       alu_b_c;
    logic               alu_cin_c;
    logic [3:0]         alu_op_c;
    logic               exec_last;
    logic               last_step;
    logic               ovf;
    logic [N-1:0]       exec_result;
    logic               exec_carry;
    logic               req_illegal;
    logic               shift_fill;

    // One-bit logical/arithmetic right shift with an explicit fill bit.
    function automatic logic [N-1:0] shr1(input logic [N-1:0] v, input logic fill);
        return {fill, v[N-1:1]};
    endfunction

    assign req_illegal = (bus.req_op > OP_SRA);
    assign shift_fill  = (op_q == OP_SRA) && sign_q;

    // shamt == 0 still needs one cycle. Otherwise the last step is pass shamt-1.
    assign last_step = (shamt_q == '0) || (pass_q == shamt_q - SHAMT_W'(1));

    // Signed overflow of the subtract pass: the operand signs differ and the
    // difference's sign differs from a's sign.
    assign ovf = (acc_q[N-1] != b_q[N-1]) && (bus.alu_out[N-1] != acc_q[N-1]);

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state, ALU pass programs and result decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        alu_a_c     = '0;
        alu_b_c     = '0;
        alu_cin_c   = 1'b0;
        alu_op_c    = ALU_AND;
        exec_last   = 1'b1;
        exec_result = bus.alu_out;
        exec_carry  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_illegal) begin
                        state_d = DONE;
                    end else if ((bus.req_op == OP_SRL) || (bus.req_op == OP_SRA)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end

            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        alu_a_c    = acc_q;
                        alu_b_c    = b_q;
                        alu_op_c   = ALU_ADD;
                        exec_carry = bus.alu_carry_out;
                    end
                    OP_SUB: begin
                        alu_a_c    = acc_q;
                        alu_b_c    = b_q;
                        alu_cin_c  = 1'b1;
                        alu_op_c   = ALU_SUB;
                        exec_carry = bus.alu_carry_out;
                    end
                    OP_AND: begin
                        alu_a_c  = acc_q;
                        alu_b_c  = b_q;
                        alu_op_c = ALU_AND;
                    end
                    OP_OR: begin
                        alu_a_c  = acc_q;
                        alu_b_c  = b_q;
                        alu_op_c = ALU_OR;
                    end
                    OP_XOR: begin
                        exec_last = (pass_q == SHAMT_W'(2));
                        case (pass_q)
                            SHAMT_W'(0): begin
                                alu_a_c  = acc_q;
                                alu_b_c  = b_q;
                                alu_op_c = ALU_AND;
                            end
                            SHAMT_W'(1): begin
                                alu_a_c  = acc_q;
                                alu_b_c  = b_q;
                                alu_op_c = ALU_OR;
                            end
                            default: begin
                                // (a | b) & ~(a & b)
                                alu_a_c  = u_q;
                                alu_b_c  = t_q;
                                alu_op_c = ALU_ANDN;
                            end
                        endcase
                    end
                    OP_SLT: begin
                        alu_a_c     = acc_q;
                        alu_b_c     = b_q;
                        alu_cin_c   = 1'b1;
                        alu_op_c    = ALU_SUB;
                        exec_result = {{(N-1){1'b0}}, bus.alu_out[N-1] ^ ovf};
                    end
                    OP_SLTU: begin
                        // No carry out of a + ~b + 1 means a borrow, i.e. a < b.
                        alu_a_c     = acc_q;
                        alu_b_c     = b_q;
                        alu_cin_c   = 1'b1;
                        alu_op_c    = ALU_SUB;
                        exec_result = {{(N-1){1'b0}}, ~bus.alu_carry_out};
                    end
                    OP_SLL: begin
                        // acc + acc doubles acc. shamt 0 is one pass of a + 0.
                        alu_a_c   = acc_q;
                        alu_b_c   = (shamt_q == '0) ? '0 : acc_q;
                        alu_op_c  = ALU_ADD;
                        exec_last = last_step;
                    end
                    default: begin
                        exec_last = 1'b1;
                    end
                endcase
                if (exec_last) begin
                    state_d = DONE;
                end
            end

            SHIFT: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers: request capture, pass results, response
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            t_q       <= '0;
            u_q       <= '0;
            shamt_q   <= '0;
            pass_q    <= '0;
            sign_q    <= 1'b0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q      <= bus.req_op;
                        acc_q     <= bus.req_a;
                        b_q       <= bus.req_b;
                        shamt_q   <= bus.req_b[SHAMT_W-1:0];
                        sign_q    <= bus.req_a[N-1];
                        pass_q    <= '0;
                        res_q     <= '0;
                        carry_q   <= 1'b0;
                        illegal_q <= req_illegal;
                    end
                end

                EXEC: begin
                    pass_q <= pass_q + SHAMT_W'(1);
                    if (op_q == OP_XOR) begin
                        if (pass_q == SHAMT_W'(0)) begin
                            t_q <= bus.alu_out;
                        end
                        if (pass_q == SHAMT_W'(1)) begin
                            u_q <= bus.alu_out;
                        end
                    end
                    if (op_q == OP_SLL) begin
                        acc_q <= bus.alu_out;
                    end
                    if (exec_last) begin
                        res_q   <= exec_result;
                        carry_q <= exec_carry;
                    end
                end

                SHIFT: begin
                    pass_q <= pass_q + SHAMT_W'(1);
                    acc_q  <= shr1(acc_q, shift_fill);
                    if (last_step) begin
                        res_q <= (shamt_q == '0) ? acc_q : shr1(acc_q, shift_fill);
                    end
                end

                default: begin
                    // DONE keeps the response registers frozen until the handshake.
                end
            endcase
        end
    end

    // ALU drive is quiet (all zero) outside EXEC because the decode defaults
    // to zero in every other state.
    assign bus.alu_a         = alu_a_c;
    assign bus.alu_b         = alu_b_c;
    assign bus.alu_carry_in  = alu_cin_c;
    assign bus.alu_operation = alu_op_c;

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == DONE);
    assign bus.rsp_result  = res_q;
    assign bus.rsp_carry   = carry_q;
    assign bus.rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int N       = 64;
    localparam int SHAMT_W = 6;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.N(N)) bus ();

    alu_op_sequencer #(.N(N), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ripple-carry ALU, {Ainvert, Binvert, sel}
    logic [N-1:0] m_a, m_b;
    logic [N:0]   m_sum;
    always_comb begin
        m_a   = bus.alu_operation[3] ? ~bus.alu_a : bus.alu_a;
        m_b   = bus.alu_operation[2] ? ~bus.alu_b : bus.alu_b;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + {{N{1'b0}}, bus.alu_carry_in};
        case (bus.alu_operation[1:0])
            2'b00:   bus.alu_out = m_a & m_b;
            2'b01:   bus.alu_out = m_a | m_b;
            2'b10:   bus.alu_out = m_sum[N-1:0];
            default: bus.alu_out = '0;
        endcase
    end
    assign bus.alu_carry_out = m_sum[N];

    // Issue one request from IDLE and wait for its response (rsp_ready held 1).
    // edges counts clock edges from the accept edge to rsp_valid; -1 on timeout.
    task automatic run_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] res, output logic carry, output logic ill,
                          output int edges);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        edges = 1;
        while (!bus.rsp_valid && edges < 300) begin
            @(posedge clk); #1;
            edges++;
        end
        res   = bus.rsp_result;
        carry = bus.rsp_carry;
        ill   = bus.rsp_illegal;
        if (!bus.rsp_valid) edges = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_result, bus.rsp_carry, bus.rsp_illegal} !== {{N{1'b0}}, 2'b00}) begin errors++; $display("FAIL reset_rsp: got %h/%b/%b expected 0/0/0", bus.rsp_result, bus.rsp_carry, bus.rsp_illegal); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_carry_in, bus.alu_operation} !== '0) begin errors++; $display("FAIL reset_alu: got a=%h b=%h cin=%b op=%b expected all 0", bus.alu_a, bus.alu_b, bus.alu_carry_in, bus.alu_operation); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        logic [N-1:0] r; logic c, il; int e;
        run_op(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, r, c, il, e);
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL add_result: got %h expected 0", r); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL add_carry: got %b expected 1", c); end
        checks++; if (e !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", e); end
        run_op(4'd1, 64'd5, 64'd7, r, c, il, e);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h expected fffffffffffffffe", r); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_carry: got %b expected 0", c); end
        checks++; if (e !== 2) begin errors++; $display("FAIL sub_latency: got %0d expected 2", e); end
    endtask

    task automatic test_and_or();
        logic [N-1:0] r; logic c, il; int e;
        // All-ones A makes the ALU adder carry out; AND must still report carry 0.
        run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_00FF, r, c, il, e);
        checks++; if (r !== 64'h8000_0000_0000_00FF) begin errors++; $display("FAIL and_result: got %h expected 80000000000000ff", r); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL and_carry: got %b expected 0", c); end
        run_op(4'd3, 64'hF0F0, 64'hFF00, r, c, il, e);
        checks++; if (r !== 64'hFFF0) begin errors++; $display("FAIL or_result: got %h expected fff0", r); end
    endtask

    task automatic test_xor();
        logic [3:0] ops [3];
        int e;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd4; bus.req_a = 64'hF0F0; bus.req_b = 64'hFF00;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        e = 1;
        for (int i = 0; i < 3; i++) begin
            ops[i] = bus.alu_operation;
            @(posedge clk); #1;
            e++;
        end
        checks++; if ({ops[0], ops[1], ops[2]} !== 12'b0000_0001_0100) begin errors++; $display("FAIL xor_op_seq: got %b %b %b expected 0000 0001 0100", ops[0], ops[1], ops[2]); end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL xor_latency: rsp_valid %b at edge %0d expected 1", bus.rsp_valid, e); end
        checks++; if (bus.rsp_result !== 64'h0FF0) begin errors++; $display("FAIL xor_result: got %h expected 0ff0", bus.rsp_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_slt();
        logic [N-1:0] r; logic c, il; int e;
        run_op(4'd5, 64'h8000_0000_0000_0000, 64'd1, r, c, il, e);
        checks++; if (r !== 64'd1) begin errors++; $display("FAIL slt_ovf: got %h expected 1", r); end
        run_op(4'd6, 64'h8000_0000_0000_0000, 64'd1, r, c, il, e);
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL sltu_big: got %h expected 0", r); end
        run_op(4'd5, 64'd5, 64'd5, r, c, il, e);
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL slt_equal: got %h expected 0", r); end
        run_op(4'd5, 64'd1, 64'h8000_0000_0000_0000, r, c, il, e);
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL slt_pos_neg: got %h expected 0", r); end
        run_op(4'd6, 64'd1, 64'h8000_0000_0000_0000, r, c, il, e);
        checks++; if (r !== 64'd1) begin errors++; $display("FAIL sltu_small: got %h expected 1", r); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL sltu_carry: got %b expected 0", c); end
    endtask

    task automatic test_shift();
        logic [N-1:0] r; logic c, il; int e;
        run_op(4'd7, 64'd1, 64'd63, r, c, il, e);
        checks++; if (r !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL sll_63: got %h expected 8000000000000000", r); end
        checks++; if (e !== 64) begin errors++; $display("FAIL sll_latency: got %0d expected 64", e); end
        run_op(4'd9, 64'h8000_0000_0000_0000, 64'd4, r, c, il, e);
        checks++; if (r !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL sra_4: got %h expected f800000000000000", r); end
        checks++; if (e !== 5) begin errors++; $display("FAIL sra_latency: got %0d expected 5", e); end
        run_op(4'd8, 64'h8000_0000_0000_0000, 64'd4, r, c, il, e);
        checks++; if (r !== 64'h0800_0000_0000_0000) begin errors++; $display("FAIL srl_4: got %h expected 0800000000000000", r); end
        run_op(4'd8, 64'h1234, 64'h40, r, c, il, e);
        checks++; if (r !== 64'h1234) begin errors++; $display("FAIL srl_shamt0: got %h expected 1234", r); end
        checks++; if (e !== 2) begin errors++; $display("FAIL srl_shamt0_latency: got %0d expected 2", e); end
        run_op(4'd7, 64'h1234, 64'h40, r, c, il, e);
        checks++; if (r !== 64'h1234) begin errors++; $display("FAIL sll_shamt0: got %h expected 1234", r); end
        run_op(4'd7, 64'd3, 64'h104, r, c, il, e);
        checks++; if (r !== 64'h30) begin errors++; $display("FAIL sll_upper_ignored: got %h expected 30", r); end
    endtask

    task automatic test_backpressure();
        int n;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_a = 64'd3; bus.req_b = 64'd4;
        @(posedge clk); #1;
        // Second request presented immediately and held.
        bus.req_op = 4'd3; bus.req_a = 64'h0F; bus.req_b = 64'hF0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'd7 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b result=%h req_ready=%b expected 1/7/0", i, bus.rsp_valid, bus.rsp_result, bus.req_ready); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b req_ready=%b expected 0/1", bus.rsp_valid, bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: req_ready got %b expected 0", bus.req_ready); end
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'hFF) begin errors++; $display("FAIL bp_second_result: got valid=%b result=%h expected 1/ff", bus.rsp_valid, bus.rsp_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] exp_acc;
        logic seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd7; bus.req_a = 64'd1; bus.req_b = 64'd63;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        exp_acc = 64'd1 << 29;
        checks++; if (bus.alu_operation !== 4'b0010 || bus.alu_a !== exp_acc) begin errors++; $display("FAIL mid_sll_pass30: got op=%b a=%h expected 0010/%h", bus.alu_operation, bus.alu_a, exp_acc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_handshake: got req_ready=%b rsp_valid=%b expected 1/0", bus.req_ready, bus.rsp_valid); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_carry_in, bus.alu_operation} !== '0 || bus.rsp_result !== '0) begin errors++; $display("FAIL mid_reset_outputs: got op=%b a=%h result=%h expected 0", bus.alu_operation, bus.alu_a, bus.rsp_result); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_rsp: rsp_valid seen %b expected 0", seen); end
    endtask

    task automatic test_illegal();
        logic [N-1:0] r; logic c, il; int e;
        run_op(4'd12, 64'h55, 64'h66, r, c, il, e);
        checks++; if (il !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b expected 1", il); end
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL illegal_result: got %h expected 0", r); end
        checks++; if (e !== 1) begin errors++; $display("FAIL illegal_latency: got %0d expected 1", e); end
        run_op(4'd0, 64'd2, 64'd3, r, c, il, e);
        checks++; if (il !== 1'b0 || r !== 64'd5) begin errors++; $display("FAIL after_illegal: got illegal=%b result=%h expected 0/5", il, r); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_add_sub();
        test_and_or();
        test_xor();
        test_slt();
        test_shift();
        test_backpressure();
        test_reset_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle execute-stage sequencer that sits upstream of the N-bit ripple-carry ALU.
- Drives the ALU's operand, carry-in and 4-bit Operation inputs, and captures its result and carry-out.
- Accepts RISC-V integer ops over a valid/ready request channel and returns results over a valid/ready response channel.
- Ops the ALU cannot do in one pass (XOR, SLT, SLTU, SLL) are built from repeated ALU passes. SRL/SRA use an internal shifter.

Parameters:
- N, 64: datapath width; must equal the attached ALU's N.
- SHAMT_W, 6: shift-amount width; must equal clog2(N).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10-15 illegal
- req_a  in  N  operand A
- req_b  in  N  operand B (shift amount = req_b[SHAMT_W-1:0])
- alu_a  out  N  to ALU A
- alu_b  out  N  to ALU B
- alu_carry_in  out  1  to ALU carry-in
- alu_operation  out  4  to ALU Operation, encoded {Ainvert, Binvert, sel[1:0]}; sel 00 AND, 01 OR, 10 ADD
- alu_out  in  N  from ALU
- alu_carry_out  in  1  from ALU
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer ready
- rsp_result  out  N  result
- rsp_carry  out  1  ALU carry-out for ADD/SUB, else 0
- rsp_illegal  out  1  set for opcodes 10-15

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- On reset assertion, mid-operation included, the in-flight transaction is discarded. Outputs:
  - state=IDLE, req_ready=1, rsp_valid=0
  - rsp_result=0, rsp_carry=0, rsp_illegal=0
  - alu_a=alu_b=0, alu_carry_in=0, alu_operation=4'b0000
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE:
  - req_ready=1 only in IDLE.
  - On accept, register op, a, b. Pass counter=0.
  - Next state is EXEC, or SHIFT for SRL/SRA.
  - Illegal op goes directly to DONE with result 0 and rsp_illegal=1.
- EXEC: one ALU pass per cycle. ALU inputs come from registers, and alu_out is captured at the cycle-ending edge. Pass programs:
  - ADD: 0010, cin 0, one pass.
  - SUB: 0110, cin 1, one pass.
  - AND: 0000, one pass.
  - OR: 0001, one pass.
  - XOR, 3 passes:
    - pass 0: AND(a,b) to t.
    - pass 1: OR(a,b) to u.
    - pass 2: alu_a=u, alu_b=t, op 0100 (u & ~t).
  - SLT: SUB pass.
    - ovf = (a[N-1]!=b[N-1]) && (alu_out[N-1]!=a[N-1]).
    - result = {0..., alu_out[N-1]^ovf}.
  - SLTU: SUB pass; result = {0..., ~alu_carry_out}.
  - SLL: shamt passes of ADD with alu_a=alu_b=acc, cin 0, acc initialised to a. shamt=0 takes one pass of ADD(a,0).
- SHIFT: SRL/SRA shift acc right by 1 per cycle, shamt cycles.
  - SRA fills with the original a[N-1].
  - shamt=0 takes one cycle with result=a.
- DONE:
  - rsp_valid=1. rsp_result, rsp_carry and rsp_illegal are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE and clear rsp_valid.
- Latency: rsp_valid rises at the edge ending the final pass/shift cycle. From the accept edge, single-pass ops take 2 edges and XOR takes 4.
- Throughput: no overlap. The next accept is possible in the cycle after the response handshake.
- ALU inputs outside EXEC: alu_operation=0000, alu_a=alu_b=0, cin 0.
- Simultaneous events: req_valid during busy is ignored (req_ready=0). The request must be held by the producer.
- Arithmetic wraps mod 2^N.
- Shift amount uses only the low SHAMT_W bits of b; upper bits are ignored.

Test Plan:
- ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> rsp_result 0, rsp_carry 1, rsp_valid 2 edges after accept. SUB 5-7 -> 0xFFFF_FFFF_FFFF_FFFE, rsp_carry 0.
- XOR a=0xF0F0, b=0xFF00 -> 0x0FF0. Monitor alu_operation sequence 0000, 0001, 0100 over 3 EXEC cycles.
- SLT a=0x8000_0000_0000_0000, b=1 -> 1 (overflow path). SLTU same operands -> 0. SLT a=b -> 0.
- SLL a=1, b=63 -> 0x8000_0000_0000_0000 after 63 passes. SRA a=0x8000_0000_0000_0000, b=4 -> 0xF800_0000_0000_0000. SRL same -> 0x0800_0000_0000_0000. b=0x40 (shamt 0) -> result=a in one cycle.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> result stable, req_ready=0, second request held. Then rsp_ready=1 -> IDLE, second request accepted the next cycle.
- rst_n pulsed low during the 30th SLL pass -> all outputs at reset values immediately (async), no rsp_valid afterward. req_op=12 -> rsp_illegal=1, result 0.
